// File: rtl/axi_pkg.sv
// Shared AXI constants, response codes and default-slave FSM states.
// Imported by the default slave; no ports.
package axi_pkg;

  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDATA = 2'd1,
    WDATA = 2'd2,
    WRESP = 2'd3
  } sd_state_t;

endpackage

// File: rtl/axi_default_slave.sv
// AXI default slave: completes every unmapped access with DECERR.
// Ports: AR/R read channels, AW/W/B write channels, ACLK, ARESETn.
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = AXI_IDS_BITS,
  parameter int ADDR_W = AXI_ADDR_BITS,
  parameter int DATA_W = AXI_DATA_BITS,
  parameter int LEN_W  = AXI_LEN_BITS
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   ARID_S,
  input  logic [ADDR_W-1:0] ARADDR_S,
  input  logic [LEN_W-1:0]  ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  output logic [ID_W-1:0]   RID_S,
  output logic [DATA_W-1:0] RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  input  logic [ID_W-1:0]   AWID_S,
  input  logic [ADDR_W-1:0] AWADDR_S,
  input  logic [LEN_W-1:0]  AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  input  logic [DATA_W-1:0] WDATA_S,
  input  logic [DATA_W/8-1:0] WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  output logic [ID_W-1:0]   BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S
);

  sd_state_t        state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  logic st_idle, st_rd, st_wd, st_wr;
  logic last_beat;

  // Address, size, burst and write payload are never inspected.
  logic unused_inputs;
  assign unused_inputs = ^{ARADDR_S, ARSIZE_S,
                           ARBURST_S, AWADDR_S,
                           AWLEN_S, AWSIZE_S,
                           AWBURST_S, WDATA_S,
                           WSTRB_S};

  assign st_idle = (state_q == IDLE);
  assign st_rd   = (state_q == RDATA);
  assign st_wd   = (state_q == WDATA);
  assign st_wr   = (state_q == WRESP);

  assign last_beat = (cnt_q == len_q);

  // Read wins a same-cycle AR/AW collision.
  assign ARREADY_S = st_idle;
  assign AWREADY_S = st_idle && !ARVALID_S;

  assign RVALID_S = st_rd;
  assign RID_S    = st_rd ? id_q : '0;
  assign RDATA_S  = '0;
  assign RRESP_S  = st_rd ? DECERR : OKAY;
  assign RLAST_S  = st_rd && last_beat;

  assign WREADY_S = st_wd;

  assign BVALID_S = st_wr;
  assign BID_S    = st_wr ? id_q : '0;
  assign BRESP_S  = st_wr ? DECERR : OKAY;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      st_idle: begin
        if (ARVALID_S) begin
          id_d    = ARID_S;
          len_d   = ARLEN_S;
          cnt_d   = '0;
          state_d = RDATA;
        end else if (AWVALID_S) begin
          id_d    = AWID_S;
          state_d = WDATA;
        end
      end
      st_rd: begin
        if (RREADY_S) begin
          // Counter stops at len, so it never wraps.
          if (last_beat) state_d = IDLE;
          else cnt_d = cnt_q + 1'b1;
        end
      end
      st_wd: begin
        // WLAST ends the burst whatever AWLEN said.
        if (WVALID_S && WLAST_S) state_d = WRESP;
      end
      st_wr: begin
        if (BREADY_S) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_default_slave.sv
// Bench for axi_default_slave: transaction-level model plus directed
// scenarios with literal expectations.
module tb_axi_default_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  arid = '0, awid = '0;
  logic [31:0] araddr = '0, awaddr = '0;
  logic [3:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = '0, awsize = '0;
  logic [1:0]  arburst = '0, awburst = '0;
  logic        arvalid = 1'b0, awvalid = 1'b0;
  logic        rready = 1'b0, bready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0;

  logic        arready, awready, wready;
  logic [7:0]  rid, bid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, bvalid;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_default_slave dut (
    .ACLK(clk), .ARESETn(rst_n),
    .ARID_S(arid), .ARADDR_S(araddr),
    .ARLEN_S(arlen), .ARSIZE_S(arsize),
    .ARBURST_S(arburst), .ARVALID_S(arvalid),
    .ARREADY_S(arready),
    .RID_S(rid), .RDATA_S(rdata),
    .RRESP_S(rresp), .RLAST_S(rlast),
    .RVALID_S(rvalid), .RREADY_S(rready),
    .AWID_S(awid), .AWADDR_S(awaddr),
    .AWLEN_S(awlen), .AWSIZE_S(awsize),
    .AWBURST_S(awburst), .AWVALID_S(awvalid),
    .AWREADY_S(awready),
    .WDATA_S(wdata), .WSTRB_S(wstrb),
    .WLAST_S(wlast), .WVALID_S(wvalid),
    .WREADY_S(wready),
    .BID_S(bid), .BRESP_S(bresp),
    .BVALID_S(bvalid), .BREADY_S(bready)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Model: queue of R beats still owed, an open
  // write burst, and queue of B responses owed.
  typedef struct {
    logic [7:0] id;
    logic       last;
  } beat_t;

  beat_t      rq[$];
  logic [7:0] bq[$];
  logic       w_open = 1'b0;
  logic [7:0] w_id = '0;

  initial begin : model
    logic idle, ar_hs, aw_hs, r_hs, w_end, b_hs;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rq.delete();
        bq.delete();
        w_open = 1'b0;
      end
      idle = (rq.size() == 0) && !w_open &&
             (bq.size() == 0);
      chk("m_arready", arready, idle);
      chk("m_awready", awready, idle && !arvalid);
      chk("m_rvalid", rvalid, rq.size() != 0);
      chk("m_rdata", rdata, 0);
      if (rq.size() != 0) begin
        chk("m_rid", rid, rq[0].id);
        chk("m_rlast", rlast, rq[0].last);
        chk("m_rresp", rresp, 2'b11);
      end else begin
        chk("m_rlast0", rlast, 0);
        chk("m_rresp0", rresp, 0);
      end
      chk("m_wready", wready, w_open);
      chk("m_bvalid", bvalid, bq.size() != 0);
      if (bq.size() != 0) begin
        chk("m_bid", bid, bq[0]);
        chk("m_bresp", bresp, 2'b11);
      end else begin
        chk("m_bresp0", bresp, 0);
      end
      @(posedge clk);
      if (rst_n) begin
        ar_hs = idle && arvalid;
        aw_hs = idle && !arvalid && awvalid;
        r_hs  = (rq.size() != 0) && rready;
        w_end = w_open && wvalid && wlast;
        b_hs  = (bq.size() != 0) && bready;
        if (r_hs) void'(rq.pop_front());
        if (b_hs) void'(bq.pop_front());
        if (w_end) begin
          w_open = 1'b0;
          bq.push_back(w_id);
        end
        if (ar_hs) begin
          for (int i = 0; i <= int'(arlen); i++)
            rq.push_back('{id: arid,
                           last: (i == int'(arlen))});
        end
        if (aw_hs) begin
          w_open = 1'b1;
          w_id   = awid;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int hs;
    logic rr_pat [4];
    rr_pat[0] = 1'b0; rr_pat[1] = 1'b1;
    rr_pat[2] = 1'b0; rr_pat[3] = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rid", rid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Read burst of 4
    arid = 8'h15; arlen = 4'd3;
    arvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("rd_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rd_rvalid", rvalid, 1);
      chk("rd_rid", rid, 8'h15);
      chk("rd_rresp", rresp, 2'b11);
      chk("rd_rlast", rlast, i == 3);
      tick();
    end
    @(negedge clk);
    chk("rd_done_rvalid", rvalid, 0);
    chk("rd_done_arready", arready, 1);
    tick();

    // Read with backpressure
    arid = 8'h33; arlen = 4'd1;
    arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      rready = rr_pat[i];
      @(negedge clk);
      chk("bp_rvalid", rvalid, 1);
      chk("bp_rid", rid, 8'h33);
      chk("bp_rlast", rlast, hs == 1);
      if (rready) hs++;
      tick();
    end
    @(negedge clk);
    chk("bp_done", rvalid, 0);
    tick();

    // Write burst of 3, B held off 3 cycles
    awid = 8'h2A; awlen = 4'd2; awvalid = 1'b1;
    @(negedge clk);
    chk("wr_awready", awready, 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wlast = (i == 2);
      wdata = 32'hA0 + i;
      @(negedge clk);
      chk("wr_wready", wready, 1);
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_bvalid_hold", bvalid, 1);
      chk("wr_bid", bid, 8'h2A);
      chk("wr_bresp", bresp, 2'b11);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("wr_bdone", bvalid, 0);
    tick();

    // AR/AW collision
    arid = 8'h44; arlen = 4'd0; arvalid = 1'b1;
    awid = 8'h55; awvalid = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("col_awready", awready, 0);
    chk("col_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    chk("col_rid", rid, 8'h44);
    chk("col_rlast", rlast, 1);
    chk("col_awready_rd", awready, 0);
    tick();
    @(negedge clk);
    chk("col_awready_after", awready, 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b1; wlast = 1'b1;
    @(negedge clk);
    chk("col_wready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("col_bid", bid, 8'h55);
    tick();
    bready = 1'b0;

    // Reset in the middle of an 8-beat read
    arid = 8'h66; arlen = 4'd7; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rr_rvalid", rvalid, 1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("rr_drop", rvalid, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rr_arready", arready, 1);
    arid = 8'h77; arlen = 4'd0; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    @(negedge clk);
    chk("rr_one_rvalid", rvalid, 1);
    chk("rr_one_rlast", rlast, 1);
    chk("rr_one_rresp", rresp, 2'b11);
    tick();
    @(negedge clk);
    chk("rr_one_done", rvalid, 0);
    tick();
    rready = 1'b0;

    // W arriving before AW
    wvalid = 1'b1; wlast = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("ew_stall", wready, 0);
      tick();
    end
    awid = 8'h12; awvalid = 1'b1;
    @(negedge clk);
    chk("ew_stall_aw", wready, 0);
    tick();
    awvalid = 1'b0;
    @(negedge clk);
    chk("ew_wready", wready, 1);
    tick();
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("ew_bvalid", bvalid, 1);
    chk("ew_bid", bid, 8'h12);
    chk("ew_bresp", bresp, 2'b11);
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("ew_idle", arready, 1);
    tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
